truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_if.sv | 25 ++
 rtl/truth_table_sweeper.sv | 124 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and its environment.
// The sweeper drives the 4-bit test vector and the result fields.
// The environment drives the sweep request and the response of the
// function under test.
interface truth_table_sweeper_if;
  logic        start;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;

  modport slave (
    input  start, f_in,
    output abcd, busy, done, pass, table_out, mismatch_count, first_fail
  );

  modport master (
    output start, f_in,
    input  abcd, busy, done, pass, table_out, mismatch_count, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive tester for a 4-input combinational block.
// A sweep walks abcd through minterms 0..15. Each vector is held for
// SETTLE cycles and f_in is captured on the last of them. The captured
// table is then scored against EXPECTED: pass flag, mismatch count and
// lowest failing minterm.
module truth_table_sweeper #(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'hAAF8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);

  localparam logic [3:0] LAST_HOLD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt;
  logic [3:0]  abcd_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [15:0] table_q;
  logic [4:0]  mismatch_q;
  logic [3:0]  first_fail_q;
  logic        accept;
  logic        sample;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  // Scanning from the top down lets the lowest set bit win; an all-zero
  // vector yields index 0.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. The sweep ends on the sample of minterm 15, so abcd never wraps.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (hold_cnt == LAST_HOLD) begin
          sample = 1'b1;
          if (abcd_q == 4'hF) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Vector generation, response capture and result scoring. done is a
  // registered one-cycle pulse issued as the DONE state is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      abcd_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      table_q      <= '0;
      mismatch_q   <= '0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hold_cnt     <= '0;
        abcd_q       <= '0;
        busy_q       <= 1'b1;
        pass_q       <= 1'b0;
        table_q      <= '0;
        mismatch_q   <= '0;
        first_fail_q <= '0;
      end else if (state_q == SWEEP) begin
        if (sample) begin
          table_q[abcd_q] <= bus.f_in;
          hold_cnt        <= '0;
          if (abcd_q != 4'hF) abcd_q <= abcd_q + 4'd1;
        end else begin
          hold_cnt <= hold_cnt + 4'd1;
        end
      end else if (state_q == DONE) begin
        busy_q       <= 1'b0;
        done_q       <= 1'b1;
        pass_q       <= (table_q == EXPECTED);
        mismatch_q   <= popcount16(table_q ^ EXPECTED);
        first_fail_q <= lowest_set(table_q ^ EXPECTED);
      end
    end
  end

  assign bus.abcd           = abcd_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.table_out      = table_q;
  assign bus.mismatch_count = mismatch_q;
  assign bus.first_fail     = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. Stimulus picks response tables and
// start timing. A monitor scores every done pulse against expectations
// queued at each accepted start. Two extra instances cover the
// SETTLE = 1 and SETTLE = 15 builds.
module tb_truth_table_sweeper;

  localparam logic [15:0] GOLD = 16'hAAF8;

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    int          mm;
    int          ff;
    int          acc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc   = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] cur_table = GOLD;
  logic [15:0] gold_v    = GOLD;
  exp_t        sb[$];

  truth_table_sweeper_if ifc ();
  truth_table_sweeper_if i1 ();
  truth_table_sweeper_if i15 ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The function under test is an arbitrary truth table looked up by the applied vector.
  assign ifc.f_in = cur_table[ifc.abcd];
  assign i1.f_in  = gold_v[i1.abcd];
  assign i15.f_in = gold_v[i15.abcd];

  truth_table_sweeper #(.SETTLE(2), .EXPECTED(GOLD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );
  truth_table_sweeper #(.SETTLE(1), .EXPECTED(GOLD)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .bus(i1)
  );
  truth_table_sweeper #(.SETTLE(15), .EXPECTED(GOLD)) dut_s15 (
    .clk(clk), .rst_n(rst_n), .bus(i15)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  // Expected result: the captured table is the response table itself, scored by plain set arithmetic.
  function automatic exp_t model(input logic [15:0] tbl, input int acc);
    exp_t        e;
    logic [15:0] diff;
    diff   = tbl ^ GOLD;
    e.tbl  = tbl;
    e.pass = (tbl == GOLD);
    e.mm   = $countones(diff);
    e.ff   = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) e.ff = i;
    e.acc  = acc;
    return e;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic launch(output int acc);
    @(negedge clk) ifc.start = 1'b1;
    @(negedge clk) ifc.start = 1'b0;
    acc = cyc;
    chk("busy_after_start", int'(ifc.busy), 1);
    chk("abcd_after_start", int'(ifc.abcd), 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 1000; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic sweep(input logic [15:0] tbl);
    int acc;
    cur_table = tbl;
    launch(acc);
    sb.push_back(model(tbl, acc));
    drain();
  endtask

  // Monitor: records the vector sequence of each sweep and scores every done pulse.
  initial begin
    logic     prev_busy, prev_done;
    logic [3:0] prev_abcd;
    int       seq[$];
    exp_t     e;
    bit       ok;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    prev_abcd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seq.delete();
        prev_busy = 1'b0;
        prev_done = 1'b0;
        prev_abcd = '0;
        continue;
      end
      if (ifc.busy && !prev_busy) begin
        seq.delete();
        seq.push_back(int'(ifc.abcd));
      end else if (ifc.busy && ifc.abcd != prev_abcd) begin
        seq.push_back(int'(ifc.abcd));
      end
      if (ifc.done) begin
        chk("done_single_pulse", int'(prev_done), 0);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: done pulse at cycle %0d, required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          chk("table_out", int'(ifc.table_out), int'(e.tbl));
          chk("pass", int'(ifc.pass), int'(e.pass));
          chk("mismatch_count", int'(ifc.mismatch_count), e.mm);
          chk("first_fail", int'(ifc.first_fail), e.ff);
          chk("busy_at_done", int'(ifc.busy), 0);
          chk("done_latency", cyc - e.acc, 33);
          ok = (seq.size() == 16);
          if (ok) for (int i = 0; i < 16; i++) if (seq[i] != i) ok = 1'b0;
          chk("abcd_sequence", int'(ok), 1);
        end
      end
      prev_busy = ifc.busy;
      prev_done = ifc.done;
      prev_abcd = ifc.abcd;
    end
  end

  // Stimulus.
  initial begin
    int acc;
    int lat1, lat15;
    logic [15:0] tbl1, tbl15, rt;
    logic p1, p15;
    ifc.start = 1'b0;
    i1.start  = 1'b0;
    i15.start = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("rst_abcd", int'(ifc.abcd), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_done", int'(ifc.done), 0);
    chk("rst_pass", int'(ifc.pass), 0);
    chk("rst_table", int'(ifc.table_out), 0);
    chk("rst_mismatch", int'(ifc.mismatch_count), 0);
    chk("rst_first_fail", int'(ifc.first_fail), 0);
    @(negedge clk) rst_n = 1'b1;

    // Golden, stuck-at-0 and f = D.
    sweep(GOLD);
    sweep(16'h0000);
    sweep(16'hAAAA);

    // Randomised response tables and start timing.
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rt = 16'($urandom);
      sweep(rt);
    end

    // start pulses while busy and during the DONE state are ignored.
    cur_table = GOLD;
    launch(acc);
    sb.push_back(model(GOLD, acc));
    wait_until(acc + 4);
    ifc.start = 1'b1;
    wait_until(acc + 5);
    ifc.start = 1'b0;
    wait_until(acc + 32);
    ifc.start = 1'b1;
    wait_until(acc + 33);
    ifc.start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("no_restart_busy", int'(ifc.busy), 0);
    chk("no_restart_done", int'(ifc.done), 0);
    chk("idle_abcd_holds_15", int'(ifc.abcd), 15);

    // start held high re-triggers on the first IDLE cycle after each done.
    cur_table = 16'($urandom);
    @(negedge clk) ifc.start = 1'b1;
    @(negedge clk);
    acc = cyc;
    sb.push_back(model(cur_table, acc));
    sb.push_back(model(cur_table, acc + 34));
    wait_until(acc + 34);
    ifc.start = 1'b0;
    drain();

    // Asynchronous reset in the middle of a sweep.
    cur_table = 16'h0F0F;
    launch(acc);
    sb.push_back(model(cur_table, acc));
    for (int n = 0; n < 100; n++) begin
      if (ifc.abcd == 4'd7) break;
      @(negedge clk);
    end
    chk("reached_abcd_7", int'(ifc.abcd), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_abcd", int'(ifc.abcd), 0);
    chk("midrst_busy", int'(ifc.busy), 0);
    chk("midrst_done", int'(ifc.done), 0);
    chk("midrst_pass", int'(ifc.pass), 0);
    chk("midrst_table", int'(ifc.table_out), 0);
    chk("midrst_mismatch", int'(ifc.mismatch_count), 0);
    chk("midrst_first_fail", int'(ifc.first_fail), 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    sweep(GOLD);

    // SETTLE = 1 and SETTLE = 15 builds on the golden function.
    lat1  = -1;
    lat15 = -1;
    tbl1  = '0;
    tbl15 = '0;
    p1    = 1'b0;
    p15   = 1'b0;
    @(negedge clk);
    i1.start  = 1'b1;
    i15.start = 1'b1;
    @(negedge clk);
    i1.start  = 1'b0;
    i15.start = 1'b0;
    acc = cyc;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (i1.done && lat1 < 0) begin
        lat1 = cyc - acc;
        tbl1 = i1.table_out;
        p1   = i1.pass;
      end
      if (i15.done && lat15 < 0) begin
        lat15 = cyc - acc;
        tbl15 = i15.table_out;
        p15   = i15.pass;
      end
      if (lat1 >= 0 && lat15 >= 0) break;
    end
    chk("settle1_latency", lat1, 17);
    chk("settle1_pass", int'(p1), 1);
    chk("settle1_table", int'(tbl1), int'(GOLD));
    chk("settle15_latency", lat15, 241);
    chk("settle15_pass", int'(p15), 1);
    chk("settle15_table", int'(tbl15), int'(GOLD));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time bound in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
